// File: rtl/hazard_decoder.sv
// Hazard decoder: rebuilds hazard rectangles from a row-band mask and a column-band mask and streams them out.
// Build option HAZARD_DEC_BBOX_EN: emit a single bounding box per frame instead of the run cross product.
module hazard_decoder #(
    parameter int VEC_W     = 16,
    parameter int COORD_W   = 8,
    parameter int ROW_SHIFT = 0,
    parameter int COL_SHIFT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [VEC_W-1:0]   vec1,
    input  logic [VEC_W-1:0]   vec2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] top,
    output logic [COORD_W-1:0] left,
    output logic [COORD_W-1:0] bottom,
    output logic [COORD_W-1:0] right,
    output logic               out_last,
    output logic [6:0]         num_hazards,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [VEC_W-1:0]   row_sh_r, col_sh_r;
    logic               row_prev_r, col_prev_r;
    logic               row_nz_r, col_nz_r;
    logic [3:0]         bit_idx_r;
    logic [3:0]         rs_r [0:7];
    logic [3:0]         re_r [0:7];
    logic [3:0]         cs_r [0:7];
    logic [3:0]         ce_r [0:7];
    logic [3:0]         rcnt_r, ccnt_r;
    logic [2:0]         ri_r, ci_r;
    logic [6:0]         hazard_cnt_r;
    logic               in_ready_r, out_valid_r, out_last_r, done_r;
    logic [COORD_W-1:0] top_r, left_r, bottom_r, right_r;
    logic [6:0]         num_hazards_r;

    logic               accept_s, load_s, xfer_s, last_pair_s;
    logic [3:0]         sel_rs_s, sel_re_s, sel_cs_s, sel_ce_s;
    logic [COORD_W-1:0] top_s, left_s, bottom_s, right_s;

    // Next-state, handshake qualifiers and rectangle selection
    always_comb begin
        state_s     = state_r;
        accept_s    = in_ready_r && in_valid;
        xfer_s      = out_valid_r && out_ready;
        load_s      = (state_r == EMIT) && (!out_valid_r || (out_ready && !out_last_r));
`ifdef HAZARD_DEC_BBOX_EN
        // rcnt of 8 wraps the index to 0, so count-1 always lands on the last run
        sel_rs_s    = rs_r[0];
        sel_re_s    = re_r[rcnt_r[2:0] - 3'd1];
        sel_cs_s    = cs_r[0];
        sel_ce_s    = ce_r[ccnt_r[2:0] - 3'd1];
        last_pair_s = 1'b1;
`else
        sel_rs_s    = rs_r[ri_r];
        sel_re_s    = re_r[ri_r];
        sel_cs_s    = cs_r[ci_r];
        sel_ce_s    = ce_r[ci_r];
        last_pair_s = ({1'b0, ri_r} == (rcnt_r - 4'd1)) && ({1'b0, ci_r} == (ccnt_r - 4'd1));
`endif
        top_s       = COORD_W'(32'(sel_rs_s) << ROW_SHIFT);
        bottom_s    = COORD_W'(((32'(sel_re_s) + 32'd1) << ROW_SHIFT) - 32'd1);
        left_s      = COORD_W'(32'(sel_cs_s) << COL_SHIFT);
        right_s     = COORD_W'(((32'(sel_ce_s) + 32'd1) << COL_SHIFT) - 32'd1);
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = SCAN;
                else          state_s = IDLE;
            end
            SCAN: begin
                if (bit_idx_r == 4'd15) state_s = (row_nz_r && col_nz_r) ? EMIT : DONE;
                else                    state_s = SCAN;
            end
            EMIT: begin
                if (xfer_s && out_last_r) state_s = DONE;
                else                      state_s = EMIT;
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_s;
    end

    // Frame capture and run extraction; a run closes when the next bit is 0 (a zero is shifted in above bit 15)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_sh_r   <= '0;
            col_sh_r   <= '0;
            row_prev_r <= 1'b0;
            col_prev_r <= 1'b0;
            row_nz_r   <= 1'b0;
            col_nz_r   <= 1'b0;
            bit_idx_r  <= 4'd0;
            rcnt_r     <= 4'd0;
            ccnt_r     <= 4'd0;
            for (int i = 0; i < 8; i++) begin
                rs_r[i] <= 4'd0;
                re_r[i] <= 4'd0;
                cs_r[i] <= 4'd0;
                ce_r[i] <= 4'd0;
            end
        end else if (accept_s) begin
            row_sh_r   <= vec1;
            col_sh_r   <= vec2;
            row_prev_r <= 1'b0;
            col_prev_r <= 1'b0;
            row_nz_r   <= (vec1 != '0);
            col_nz_r   <= (vec2 != '0);
            bit_idx_r  <= 4'd0;
            rcnt_r     <= 4'd0;
            ccnt_r     <= 4'd0;
        end else if (state_r == SCAN) begin
            if (row_sh_r[0] && !row_prev_r) rs_r[rcnt_r[2:0]] <= bit_idx_r;
            if (row_sh_r[0] && !row_sh_r[1]) begin
                re_r[rcnt_r[2:0]] <= bit_idx_r;
                rcnt_r            <= rcnt_r + 4'd1;
            end
            if (col_sh_r[0] && !col_prev_r) cs_r[ccnt_r[2:0]] <= bit_idx_r;
            if (col_sh_r[0] && !col_sh_r[1]) begin
                ce_r[ccnt_r[2:0]] <= bit_idx_r;
                ccnt_r            <= ccnt_r + 4'd1;
            end
            row_prev_r <= row_sh_r[0];
            col_prev_r <= col_sh_r[0];
            row_sh_r   <= {1'b0, row_sh_r[VEC_W-1:1]};
            col_sh_r   <= {1'b0, col_sh_r[VEC_W-1:1]};
            bit_idx_r  <= bit_idx_r + 4'd1;
        end else begin
            bit_idx_r  <= bit_idx_r;
        end
    end

    // Pair walk (row run outer, column run inner) and transfer counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ri_r         <= 3'd0;
            ci_r         <= 3'd0;
            hazard_cnt_r <= 7'd0;
        end else if (accept_s) begin
            ri_r         <= 3'd0;
            ci_r         <= 3'd0;
            hazard_cnt_r <= 7'd0;
        end else begin
            if (load_s) begin
                if ({1'b0, ci_r} == (ccnt_r - 4'd1)) begin
                    ci_r <= 3'd0;
                    ri_r <= ri_r + 3'd1;
                end else begin
                    ci_r <= ci_r + 3'd1;
                end
            end
            if (xfer_s) hazard_cnt_r <= hazard_cnt_r + 7'd1;
        end
    end

    // Registered outputs; rectangle fields only change on a load, so they hold while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r    <= 1'b1;
            out_valid_r   <= 1'b0;
            out_last_r    <= 1'b0;
            done_r        <= 1'b0;
            top_r         <= '0;
            left_r        <= '0;
            bottom_r      <= '0;
            right_r       <= '0;
            num_hazards_r <= 7'd0;
        end else begin
            in_ready_r <= (state_s == IDLE);
            done_r     <= (state_s == DONE);
            if (state_s == DONE) num_hazards_r <= hazard_cnt_r + {6'd0, xfer_s};
            if (load_s) begin
                out_valid_r <= 1'b1;
                out_last_r  <= last_pair_s;
                top_r       <= top_s;
                left_r      <= left_s;
                bottom_r    <= bottom_s;
                right_r     <= right_s;
            end else if (xfer_s) begin
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_last    = out_last_r;
    assign done        = done_r;
    assign top         = top_r;
    assign left        = left_r;
    assign bottom      = bottom_r;
    assign right       = right_r;
    assign num_hazards = num_hazards_r;

endmodule

// File: tb/tb_hazard_decoder.sv
// Directed bench for hazard_decoder: latency, ordering, stall hold, empty frame and mid-frame reset.
module tb_hazard_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] vec1, vec2;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  top, left, bottom, right;
    logic        out_last;
    logic [6:0]  num_hazards;
    logic        done;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] et [0:63];
    logic [7:0] el [0:63];
    logic [7:0] eb [0:63];
    logic [7:0] er [0:63];

    hazard_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .vec1       (vec1),
        .vec2       (vec2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .top        (top),
        .left       (left),
        .bottom     (bottom),
        .right      (right),
        .out_last   (out_last),
        .num_hazards(num_hazards),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_exp(input int i, input int t, input int l, input int b, input int r);
        et[i] = 8'(t);
        el[i] = 8'(l);
        eb[i] = 8'(b);
        er[i] = 8'(r);
    endtask

    task automatic chk_rect(input string tag, input int k);
        chk({tag, "_top"},    {24'd0, top},    {24'd0, et[k]});
        chk({tag, "_left"},   {24'd0, left},   {24'd0, el[k]});
        chk({tag, "_bottom"}, {24'd0, bottom}, {24'd0, eb[k]});
        chk({tag, "_right"},  {24'd0, right},  {24'd0, er[k]});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_out_last"},  {31'd0, out_last},  32'd0);
        chk({tag, "_done"},      {31'd0, done},      32'd0);
        chk({tag, "_num"},       {25'd0, num_hazards}, 32'd0);
        chk({tag, "_coords"},    {top, left, bottom, right}, 32'd0);
    endtask

    // Sends one frame and consumes n rectangles; optionally stalls 3 cycles on rectangle stall_k
    task automatic run_frame(input string tag, input logic [15:0] v1, input logic [15:0] v2,
                             input int n, input int stall_k, output int first_cyc);
        int k   = 0;
        int cyc = 0;
        first_cyc = -1;
        vec1 = v1;
        vec2 = v2;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
        while (k < n && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            if (out_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                chk_rect(tag, k);
                chk({tag, "_last"}, {31'd0, out_last}, (k == n - 1) ? 32'd1 : 32'd0);
                if (k == stall_k) begin
                    out_ready = 1'b0;
                    repeat (3) begin
                        @(posedge clk); #1;
                        chk({tag, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
                        chk_rect({tag, "_stall"}, k);
                    end
                    out_ready = 1'b1;
                end
                k++;
            end
        end
        chk({tag, "_rect_count"}, k, n);
        @(posedge clk); #1;
        chk({tag, "_done"},      {31'd0, done},        32'd1);
        chk({tag, "_num"},       {25'd0, num_hazards}, n);
        chk({tag, "_valid_off"}, {31'd0, out_valid},   32'd0);
        @(posedge clk); #1;
        chk({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_done_off"},   {31'd0, done},     32'd0);
        chk({tag, "_num_hold"},   {25'd0, num_hazards}, n);
    endtask

    initial begin
        int fc;
        int n;
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        vec1      = 16'h0000;
        vec2      = 16'h0000;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Test 1: single rectangle, latency check
        set_exp(0, 0, 0, 1, 3);
        run_frame("t1", 16'h0003, 16'h0003, 1, -1, fc);
        chk("t1_latency", fc, 17);

        // Test 2: two row runs x two column runs
`ifdef HAZARD_DEC_BBOX_EN
        set_exp(0, 0, 0, 7, 25);
        n = 1;
`else
        set_exp(0, 0, 0, 0, 1);
        set_exp(1, 0, 22, 0, 25);
        set_exp(2, 6, 0, 7, 1);
        set_exp(3, 6, 22, 7, 25);
        n = 4;
`endif
        run_frame("t2", 16'h00C1, 16'h1801, n, -1, fc);
        chk("t2_latency", fc, 17);

        // Test 3: empty row mask -> straight to done
        vec1 = 16'h0000;
        vec2 = 16'hFFFF;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 0;
        repeat (16) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
            if (done) seen = seen + 100;
        end
        chk("t3_no_valid_early", seen, 100);
        chk("t3_done",     {31'd0, done},        32'd1);
        chk("t3_num",      {25'd0, num_hazards}, 32'd0);
        @(posedge clk); #1;
        chk("t3_ready",    {31'd0, in_ready},  32'd1);
        chk("t3_valid",    {31'd0, out_valid}, 32'd0);
        chk("t3_done_off", {31'd0, done},      32'd0);

        // Test 4: 8x8 unit rectangles with a stall on rectangle #5
`ifdef HAZARD_DEC_BBOX_EN
        set_exp(0, 0, 0, 14, 29);
        n = 1;
`else
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                set_exp(r * 8 + c, 2 * r, 4 * c, 2 * r, 4 * c + 1);
        n = 64;
`endif
        run_frame("t4", 16'h5555, 16'h5555, n, 4, fc);

        // Test 5: reset after two transfers, then re-send the frame
        vec1 = 16'h00C1;
        vec2 = 16'h1801;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 0;
        while (!out_valid && seen < 40) begin
            @(posedge clk); #1;
            seen++;
        end
        chk("t5_valid_seen", {31'd0, out_valid}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t5_reset");
        @(posedge clk); #1;
        chk_reset_outputs("t5_reset_hold");
        rst_n = 1'b1;
`ifdef HAZARD_DEC_BBOX_EN
        set_exp(0, 0, 0, 7, 25);
        n = 1;
`else
        set_exp(0, 0, 0, 0, 1);
        set_exp(1, 0, 22, 0, 25);
        set_exp(2, 6, 0, 7, 1);
        set_exp(3, 6, 22, 7, 25);
        n = 4;
`endif
        run_frame("t5", 16'h00C1, 16'h1801, n, -1, fc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
